// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - 4-LED pattern sequencer with debounced mode/speed buttons

module led_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [1:0]    sync_fill;
    logic          db_state;
    logic          db_prev;
    logic          armed;
    logic [DW-1:0] db_cnt;

    // armed blocks the rising edge of a button already held through reset;
    // it sets only once the refilled synchroniser shows a settled release.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_fill <= 2'b00;
            db_state  <= 1'b0;
            db_prev   <= 1'b0;
            armed     <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync_1    <= btn_i;
            sync_2    <= sync_1;
            sync_fill <= {sync_fill[0], 1'b1};
            db_prev   <= db_state;
            if (sync_2 == db_state) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_state <= ~db_state;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            if (sync_fill[1] && !sync_2 && !db_state) begin
                armed <= 1'b1;
            end
        end
    end

    assign press_o = db_state & ~db_prev & armed;

endmodule

module led_pattern_sequencer #(
    parameter int STEP_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_mode_i,
    input  logic       btn_speed_i,
    output logic       LED_1_o,
    output logic       LED_2_o,
    output logic       LED_3_o,
    output logic       LED_4_o,
    output logic [1:0] mode_o,
    output logic [1:0] speed_o,
    output logic       step_o
);

    localparam int TW = $clog2(STEP_DIV + 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_RING   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [1:0]    speed_q, speed_d;
    logic [3:0]    pattern_q, pattern_d;
    logic          dir_down_q, dir_down_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [TW-1:0] tick_last;
    logic          step_q, step_d;
    logic          mode_press;
    logic          speed_press;

    led_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .btn_i   (btn_mode_i),
        .press_o (mode_press)
    );

    led_btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_speed (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .btn_i   (btn_speed_i),
        .press_o (speed_press)
    );

    assign tick_last = (TW'(STEP_DIV) >> speed_q) - TW'(1);

    always_comb begin
        mode_d     = mode_q;
        speed_d    = speed_q;
        pattern_d  = pattern_q;
        dir_down_d = dir_down_q;
        tick_d     = tick_q;
        step_d     = 1'b0;

        // Pattern advances the cycle after the step pulse; a mode press below overrides it.
        if (step_q) begin
            case (mode_q)
                MODE_RING: pattern_d = {pattern_q[2:0], pattern_q[3]};
                MODE_BOUNCE: begin
                    if (!dir_down_q) begin
                        if (pattern_q[3]) begin
                            dir_down_d = 1'b1;
                            pattern_d  = pattern_q >> 1;
                        end else begin
                            pattern_d  = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            dir_down_d = 1'b0;
                            pattern_d  = pattern_q << 1;
                        end else begin
                            pattern_d  = pattern_q >> 1;
                        end
                    end
                end
                MODE_BLINK: pattern_d = ~pattern_q;
                default: ;
            endcase
        end

        if (mode_press || speed_press) begin
            tick_d = '0;
            if (speed_press) begin
                speed_d = speed_q + 2'd1;
            end
            if (mode_press) begin
                dir_down_d = 1'b0;
                case (mode_q)
                    MODE_OFF: begin
                        mode_d    = MODE_RING;
                        pattern_d = 4'b0001;
                    end
                    MODE_RING: begin
                        mode_d    = MODE_BOUNCE;
                        pattern_d = 4'b0001;
                    end
                    MODE_BOUNCE: begin
                        mode_d    = MODE_BLINK;
                        pattern_d = 4'b1111;
                    end
                    default: begin
                        mode_d    = MODE_OFF;
                        pattern_d = 4'b0000;
                    end
                endcase
            end
        end else if (mode_q == MODE_OFF) begin
            tick_d = '0;
        end else if (tick_q == tick_last) begin
            tick_d = '0;
            step_d = 1'b1;
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mode_q     <= MODE_OFF;
            speed_q    <= 2'd0;
            pattern_q  <= 4'b0000;
            dir_down_q <= 1'b0;
            tick_q     <= '0;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            speed_q    <= speed_d;
            pattern_q  <= pattern_d;
            dir_down_q <= dir_down_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
        end
    end

    assign {LED_4_o, LED_3_o, LED_2_o, LED_1_o} = pattern_q;
    assign mode_o  = mode_q;
    assign speed_o = speed_q;
    assign step_o  = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer

module tb_led_pattern_sequencer;

    localparam int STEP_DIV = 16;
    localparam int DB       = 4;

    logic       clk_i       = 1'b0;
    logic       rst_n_i     = 1'b0;
    logic       btn_mode_i  = 1'b0;
    logic       btn_speed_i = 1'b0;
    logic       LED_1_o, LED_2_o, LED_3_o, LED_4_o;
    logic [1:0] mode_o;
    logic [1:0] speed_o;
    logic       step_o;

    always #5 clk_i = ~clk_i;

    led_pattern_sequencer #(
        .STEP_DIV        (STEP_DIV),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .btn_mode_i  (btn_mode_i),
        .btn_speed_i (btn_speed_i),
        .LED_1_o     (LED_1_o),
        .LED_2_o     (LED_2_o),
        .LED_3_o     (LED_3_o),
        .LED_4_o     (LED_4_o),
        .mode_o      (mode_o),
        .speed_o     (speed_o),
        .step_o      (step_o)
    );

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;
    int mq[$];
    int sq[$];
    int m_mode     = 0;
    int m_speed    = 0;
    int m_k        = 0;
    int m_r        = 0;
    bit m_step     = 1'b0;
    int bounce_tab[6] = '{1, 2, 4, 8, 4, 2};

    function automatic logic [3:0] exp_leds();
        case (m_mode)
            1:       return 4'(1 << (m_k % 4));
            2:       return 4'(bounce_tab[m_k % 6]);
            3:       return (m_k % 2 == 0) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
        end
    endtask

    task automatic tick();
        bit mp;
        bit sp;
        @(posedge clk_i);
        #1;
        n++;
        mp = 1'b0;
        sp = 1'b0;
        if (mq.size() > 0 && mq[0] == n) begin
            mp = 1'b1;
            void'(mq.pop_front());
        end
        if (sq.size() > 0 && sq[0] == n) begin
            sp = 1'b1;
            void'(sq.pop_front());
        end
        if (!rst_n_i) begin
            m_mode  = 0;
            m_speed = 0;
            m_k     = 0;
            m_r     = n;
            m_step  = 1'b0;
            mq.delete();
            sq.delete();
        end else begin
            if (m_step && !mp) m_k++;
            if (mp || sp) begin
                if (mp) begin
                    m_mode = (m_mode + 1) % 4;
                    m_k    = 0;
                end
                if (sp) m_speed = (m_speed + 1) % 4;
                m_r    = n;
                m_step = 1'b0;
            end else begin
                m_step = (m_mode != 0) && ((n - m_r) % (STEP_DIV >> m_speed) == 0);
            end
        end
        check("leds",  {LED_4_o, LED_3_o, LED_2_o, LED_1_o}, exp_leds());
        check("mode",  {2'b00, mode_o},  4'(m_mode));
        check("speed", {2'b00, speed_o}, 4'(m_speed));
        check("step",  {3'b000, step_o}, {3'b000, m_step});
    endtask

    task automatic run(input int c);
        repeat (c) tick();
    endtask

    // Raw high from just after edge n gives a press acting at edge n+DB+3.
    task automatic press(input bit m, input bit s, input int hold, input int gap);
        if (hold >= DB) begin
            if (m) mq.push_back(n + DB + 3);
            if (s) sq.push_back(n + DB + 3);
        end
        btn_mode_i  = m;
        btn_speed_i = s;
        run(hold);
        btn_mode_i  = 1'b0;
        btn_speed_i = 1'b0;
        run(gap);
    endtask

    initial begin
        int sel;
        // Reset and idle
        rst_n_i = 1'b0;
        run(3);
        rst_n_i = 1'b1;
        run(100);

        // RING
        press(1, 0, 10, 8);
        run(80);

        // BOUNCE, BLINK, OFF
        press(1, 0, 6, 8);
        run(140);
        press(1, 0, 6, 8);
        run(40);
        press(1, 0, 6, 8);
        run(30);

        // Speed stepping in RING
        press(1, 0, 6, 10);
        run(20);
        for (int i = 0; i < 4; i++) begin
            press(0, 1, 5 + i, 9);
            run(25);
        end

        // Glitches then simultaneous press
        press(1, 1, 3, 10);
        press(1, 0, 2, 10);
        press(0, 1, 1, 10);
        run(20);
        press(1, 1, 7, 10);
        run(40);

        // Reset mid-BOUNCE while a button is held
        rst_n_i = 1'b0;
        run(1);
        rst_n_i = 1'b1;
        run(4);
        press(1, 0, 6, 8);
        press(1, 0, 6, 8);
        for (int i = 0; i < 200 && !(m_mode == 2 && m_k == 4); i++) tick();
        check("bounce_0100_reached", {LED_4_o, LED_3_o, LED_2_o, LED_1_o}, 4'b0100);
        btn_mode_i = 1'b1;
        run(2);
        rst_n_i = 1'b0;
        run(1);
        check("reset_mid_bounce_leds", {LED_4_o, LED_3_o, LED_2_o, LED_1_o}, 4'b0000);
        rst_n_i = 1'b1;
        run(20);
        check("held_btn_no_press", {2'b00, mode_o}, 4'd0);
        btn_mode_i = 1'b0;
        run(12);
        press(1, 0, 6, 10);
        run(40);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: press(1, 0, int'($urandom_range(DB, DB + 8)), int'($urandom_range(DB + 4, DB + 12)));
                1: press(0, 1, int'($urandom_range(DB, DB + 8)), int'($urandom_range(DB + 4, DB + 12)));
                2: press(1, 1, int'($urandom_range(DB, DB + 8)), int'($urandom_range(DB + 4, DB + 12)));
                3: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, DB - 1)), int'($urandom_range(DB + 4, DB + 12)));
                4: run(int'($urandom_range(1, 40)));
                5: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(DB, DB + 3)), int'($urandom_range(DB + 4, DB + 8)));
                default: begin
                    rst_n_i = 1'b0;
                    run(int'($urandom_range(1, 3)));
                    rst_n_i = 1'b1;
                    run(4);
                end
            endcase
        end
        run(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
